// File: rtl/bpd_bob_if.sv
// Branch outcome buffer bus: F1 allocation, execute resolution, retire/flush outputs.
// Optional statistics ports are present only when BOB_STATS_EN is defined.
interface bpd_bob_if #(
  parameter int LOG_DEPTH = 4,
  parameter int BHR_W     = 12,
  parameter int LH_W      = 10
);
  logic                 alloc_i;
  logic [63:0]          alloc_pc_i;
  logic [BHR_W-1:0]     alloc_bhr_i;
  logic [LH_W-1:0]      alloc_lochist_i;
  logic                 alloc_pred_i;
  logic                 alloc_rdy_o;
  logic [LOG_DEPTH-1:0] alloc_tag_o;

  logic                 resolve_i;
  logic [LOG_DEPTH-1:0] resolve_tag_i;
  logic                 resolve_dir_i;

  logic                 flush_o;
  logic                 bob_valid_r_o;
  logic [63:0]          bob_pc_r_o;
  logic [BHR_W-1:0]     bob_bhr_r_o;
  logic [LH_W-1:0]      bob_lochist_r_o;
  logic                 bpd_rt_ud_o;
  logic                 bpd_rt_brdir_o;
  logic [LOG_DEPTH:0]   count_o;
`ifdef BOB_STATS_EN
  logic [31:0]          stat_retired_o;
  logic [31:0]          stat_mispred_o;
`endif

  modport slave (
    input  alloc_i, alloc_pc_i, alloc_bhr_i, alloc_lochist_i, alloc_pred_i,
    input  resolve_i, resolve_tag_i, resolve_dir_i,
`ifdef BOB_STATS_EN
    output stat_retired_o, stat_mispred_o,
`endif
    output alloc_rdy_o, alloc_tag_o, flush_o, bob_valid_r_o, bob_pc_r_o,
    output bob_bhr_r_o, bob_lochist_r_o, bpd_rt_ud_o, bpd_rt_brdir_o, count_o
  );

  modport master (
    output alloc_i, alloc_pc_i, alloc_bhr_i, alloc_lochist_i, alloc_pred_i,
    output resolve_i, resolve_tag_i, resolve_dir_i,
`ifdef BOB_STATS_EN
    input  stat_retired_o, stat_mispred_o,
`endif
    input  alloc_rdy_o, alloc_tag_o, flush_o, bob_valid_r_o, bob_pc_r_o,
    input  bob_bhr_r_o, bob_lochist_r_o, bpd_rt_ud_o, bpd_rt_brdir_o, count_o
  );
endinterface

// File: rtl/bpd_bob.sv
// Branch outcome buffer: circular FIFO of in-flight conditional branches feeding PHT
// updates on in-order retire and BHR repair on mispredict. BOB_STATS_EN adds counters.
module bpd_bob #(
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4,
  parameter int BHR_W     = 12,
  parameter int LH_W      = 10
) (
  input  logic   clock,
  input  logic   reset,
  bpd_bob_if.slave bus
);

  typedef logic [LOG_DEPTH:0]   ptr_t;
  typedef logic [LOG_DEPTH-1:0] idx_t;

  localparam ptr_t WRAP_ONLY = {1'b1, {LOG_DEPTH{1'b0}}};

  ptr_t             head, tail;
  logic [DEPTH-1:0] resolved;

  logic [63:0]      pc_mem  [DEPTH];
  logic [BHR_W-1:0] bhr_mem [DEPTH];
  logic [LH_W-1:0]  lh_mem  [DEPTH];
  logic [DEPTH-1:0] pred_mem;
  logic [DEPTH-1:0] dir_mem;

  logic             flush_q, valid_q, ud_q, brdir_q;
  logic [63:0]      pc_q;
  logic [BHR_W-1:0] bhr_q;
  logic [LH_W-1:0]  lh_q;

  idx_t head_idx, tail_idx, res_tag, res_off;
  ptr_t count, rollback;
  logic full, empty, res_live, mispredict, retire, alloc_fire;

  assign head_idx = head[LOG_DEPTH-1:0];
  assign tail_idx = tail[LOG_DEPTH-1:0];
  assign res_tag  = bus.resolve_tag_i;
  assign count    = tail - head;
  assign full     = (head ^ tail) == WRAP_ONLY;
  assign empty    = head == tail;

  // A tag is live when its distance from head is below the occupancy.
  assign res_off    = res_tag - head_idx;
  assign res_live   = bus.resolve_i && ({1'b0, res_off} < count);
  assign mispredict = res_live && (bus.resolve_dir_i != pred_mem[res_tag]);
  assign retire     = !empty && resolved[head_idx] && !mispredict;
  assign alloc_fire = bus.alloc_i && !full && !mispredict;

  // Rebuilding the new tail from head keeps the wrap bit consistent.
  assign rollback = head + ptr_t'({1'b0, res_off}) + ptr_t'(1);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      resolved <= '0;
      flush_q  <= 1'b0;
      valid_q  <= 1'b0;
      ud_q     <= 1'b0;
      brdir_q  <= 1'b0;
      pc_q     <= '0;
      bhr_q    <= '0;
      lh_q     <= '0;
    end else begin
      flush_q <= 1'b0;
      valid_q <= 1'b0;
      ud_q    <= 1'b0;
      brdir_q <= 1'b0;
      pc_q    <= '0;
      bhr_q   <= '0;
      lh_q    <= '0;

      if (mispredict) begin
        flush_q <= 1'b1;
        valid_q <= 1'b1;
        pc_q    <= pc_mem[res_tag];
        bhr_q   <= {bhr_mem[res_tag][BHR_W-2:0], bus.resolve_dir_i};
        lh_q    <= lh_mem[res_tag];
      end else if (retire) begin
        valid_q <= 1'b1;
        ud_q    <= 1'b1;
        brdir_q <= dir_mem[head_idx];
        pc_q    <= pc_mem[head_idx];
        bhr_q   <= bhr_mem[head_idx];
        lh_q    <= lh_mem[head_idx];
        head    <= head + ptr_t'(1);
      end

      if (mispredict) begin
        tail <= rollback;
      end else if (alloc_fire) begin
        tail <= tail + ptr_t'(1);
      end

      if (alloc_fire) begin
        resolved[tail_idx] <= 1'b0;
      end
      if (res_live) begin
        resolved[res_tag] <= 1'b1;
      end
    end
  end

  // NOTE: payload storage has no reset; only the control bits decide whether an entry is meaningful.
  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      pc_mem[tail_idx]   <= bus.alloc_pc_i;
      bhr_mem[tail_idx]  <= bus.alloc_bhr_i;
      lh_mem[tail_idx]   <= bus.alloc_lochist_i;
      pred_mem[tail_idx] <= bus.alloc_pred_i;
    end
    if (res_live) begin
      dir_mem[res_tag] <= bus.resolve_dir_i;
    end
  end

  assign bus.alloc_rdy_o     = !full;
  assign bus.alloc_tag_o     = tail_idx;
  assign bus.count_o         = count;
  assign bus.flush_o         = flush_q;
  assign bus.bob_valid_r_o   = valid_q;
  assign bus.bob_pc_r_o      = pc_q;
  assign bus.bob_bhr_r_o     = bhr_q;
  assign bus.bob_lochist_r_o = lh_q;
  assign bus.bpd_rt_ud_o     = ud_q;
  assign bus.bpd_rt_brdir_o  = brdir_q;

`ifdef BOB_STATS_EN
  logic [31:0] stat_retired, stat_mispred;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_retired <= '0;
      stat_mispred <= '0;
    end else begin
      if (retire)     stat_retired <= stat_retired + 32'd1;
      if (mispredict) stat_mispred <= stat_mispred + 32'd1;
    end
  end

  assign bus.stat_retired_o = stat_retired;
  assign bus.stat_mispred_o = stat_mispred;
`endif

endmodule

// File: tb/tb_bpd_bob.sv
// Self-checking bench for bpd_bob: a queue-based reference model predicts every
// retire/flush output, which is pushed to a scoreboard and popped after each edge.
module tb_bpd_bob;
  localparam int DEPTH     = 16;
  localparam int LOG_DEPTH = 4;
  localparam int BHR_W     = 12;
  localparam int LH_W      = 10;

  typedef struct {
    logic [63:0]      pc;
    logic [BHR_W-1:0] bhr;
    logic [LH_W-1:0]  lh;
    logic             pred;
    logic             resolved;
    logic             dir;
  } ent_t;

  typedef struct {
    logic             flush;
    logic [63:0]      pc;
    logic [BHR_W-1:0] bhr;
    logic [LH_W-1:0]  lh;
    logic             dir;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bpd_bob_if #(.LOG_DEPTH(LOG_DEPTH), .BHR_W(BHR_W), .LH_W(LH_W)) bus ();

  bpd_bob #(.DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH), .BHR_W(BHR_W), .LH_W(LH_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  ent_t mq[$];
  exp_t sb[$];
  int   hidx = 0;
  int   ud_seen = 0;
  int   fl_seen = 0;
  bit   first_reset = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alloc_i         = 1'b0;
    bus.alloc_pc_i      = '0;
    bus.alloc_bhr_i     = '0;
    bus.alloc_lochist_i = '0;
    bus.alloc_pred_i    = 1'b0;
    bus.resolve_i       = 1'b0;
    bus.resolve_tag_i   = '0;
    bus.resolve_dir_i   = 1'b0;
  endtask

  // Reference model: one step from the inputs currently driven.
  task automatic model_step();
    int   n;
    bit   misp;
    bit   head_res;
    ent_t h;
    ent_t ne;
    exp_t e;
    n        = mq.size();
    misp     = 1'b0;
    head_res = (n > 0) && mq[0].resolved;
    if (n > 0) h = mq[0];
    if (bus.resolve_i) begin
      int off;
      off = (int'(bus.resolve_tag_i) - hidx) & (DEPTH - 1);
      if (off < n) begin
        misp = (mq[off].pred != bus.resolve_dir_i);
        mq[off].resolved = 1'b1;
        mq[off].dir      = bus.resolve_dir_i;
        if (misp) begin
          e.flush = 1'b1;
          e.pc    = mq[off].pc;
          e.bhr   = (mq[off].bhr << 1) | BHR_W'(bus.resolve_dir_i);
          e.lh    = mq[off].lh;
          e.dir   = 1'b0;
          sb.push_back(e);
          while (mq.size() > off + 1) void'(mq.pop_back());
        end
      end
    end
    if (!misp && head_res) begin
      e.flush = 1'b0;
      e.pc    = h.pc;
      e.bhr   = h.bhr;
      e.lh    = h.lh;
      e.dir   = h.dir;
      sb.push_back(e);
      void'(mq.pop_front());
      hidx = (hidx + 1) % DEPTH;
    end
    if (bus.alloc_i && !misp && n < DEPTH) begin
      ne.pc       = bus.alloc_pc_i;
      ne.bhr      = bus.alloc_bhr_i;
      ne.lh       = bus.alloc_lochist_i;
      ne.pred     = bus.alloc_pred_i;
      ne.resolved = 1'b0;
      ne.dir      = 1'b0;
      mq.push_back(ne);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (bus.bpd_rt_ud_o === 1'b1) ud_seen++;
    if (bus.flush_o === 1'b1) fl_seen++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("valid", 64'(bus.bob_valid_r_o), 64'(1));
      check("flush", 64'(bus.flush_o), 64'(e.flush));
      check("rt_ud", 64'(bus.bpd_rt_ud_o), 64'(!e.flush));
      check("pc", bus.bob_pc_r_o, e.pc);
      check("bhr", 64'(bus.bob_bhr_r_o), 64'(e.bhr));
      check("lochist", 64'(bus.bob_lochist_r_o), 64'(e.lh));
      if (!e.flush) check("brdir", 64'(bus.bpd_rt_brdir_o), 64'(e.dir));
    end else begin
      check("idle_strobes", 64'({bus.bob_valid_r_o, bus.flush_o, bus.bpd_rt_ud_o}), 64'(0));
    end
    check("count", 64'(bus.count_o), 64'(mq.size()));
    check("alloc_rdy", 64'(bus.alloc_rdy_o), 64'(mq.size() < DEPTH));
    check("alloc_tag", 64'(bus.alloc_tag_o), 64'((hidx + mq.size()) % DEPTH));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare_outputs();
    idle_inputs();
  endtask

  task automatic reset_dut();
`ifdef BOB_STATS_EN
    if (!first_reset) begin
      check("stat_retired", 64'(bus.stat_retired_o), 64'(ud_seen));
      check("stat_mispred", 64'(bus.stat_mispred_o), 64'(fl_seen));
    end
`endif
    first_reset = 1'b0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
    sb.delete();
    hidx    = 0;
    ud_seen = 0;
    fl_seen = 0;
    check("rst_strobes", 64'({bus.bob_valid_r_o, bus.flush_o, bus.bpd_rt_ud_o}), 64'(0));
    check("rst_count", 64'(bus.count_o), 64'(0));
    check("rst_rdy", 64'(bus.alloc_rdy_o), 64'(1));
  endtask

  task automatic alloc(input logic [63:0] pc, input logic [BHR_W-1:0] bhr,
                       input logic [LH_W-1:0] lh, input logic pred);
    bus.alloc_i         = 1'b1;
    bus.alloc_pc_i      = pc;
    bus.alloc_bhr_i     = bhr;
    bus.alloc_lochist_i = lh;
    bus.alloc_pred_i    = pred;
  endtask

  task automatic resolve(input int tag, input logic dir);
    bus.resolve_i     = 1'b1;
    bus.resolve_tag_i = LOG_DEPTH'(tag);
    bus.resolve_dir_i = dir;
  endtask

  // Resolve outstanding entries with their prediction and wait for the buffer to empty.
  task automatic drain();
    for (int c = 0; c < 200 && mq.size() > 0; c++) begin
      for (int k = 0; k < mq.size(); k++) begin
        if (!mq[k].resolved) begin
          resolve((hidx + k) % DEPTH, mq[k].pred);
          break;
        end
      end
      tick();
    end
    check("drain_empty", 64'(bus.count_o), 64'(0));
  endtask

  initial begin
    int start_ud;
    logic prev_pred;
    reset = 1'b1;
    idle_inputs();

    // In-order retire of three correctly predicted branches.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      alloc(64'h1000 + 64'(4 * i), BHR_W'(i), LH_W'(i), 1'b1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      resolve(i, 1'b1);
      tick();
    end
    tick();
    tick();
    check("t1_retires", 64'(ud_seen), 64'(3));
    check("t1_noflush", 64'(fl_seen), 64'(0));
    check("t1_count", 64'(bus.count_o), 64'(0));

    // Fill to capacity, reject an extra alloc, then free one slot.
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      alloc(64'h2000 + 64'(4 * i), BHR_W'(3 * i), LH_W'(5 * i), 1'(i));
      tick();
    end
    check("t2_full_rdy", 64'(bus.alloc_rdy_o), 64'(0));
    check("t2_full_count", 64'(bus.count_o), 64'(16));
    alloc(64'hDEAD, '0, '0, 1'b1);
    tick();
    check("t2_tail_hold", 64'(bus.alloc_tag_o), 64'(0));
    check("t2_count_hold", 64'(bus.count_o), 64'(16));
    resolve(0, 1'b0);
    tick();
    tick();
    check("t2_freed_rdy", 64'(bus.alloc_rdy_o), 64'(1));
    check("t2_freed_count", 64'(bus.count_o), 64'(15));
    drain();

    // Mispredict with BHR repair and rollback.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      alloc(64'h3000 + 64'(4 * i), (i == 1) ? BHR_W'(12'h0A5) : BHR_W'(i), LH_W'(i + 7), 1'b1);
      tick();
    end
    resolve(1, 1'b0);
    tick();
    check("t3_flush", 64'(bus.flush_o), 64'(1));
    check("t3_bhr", 64'(bus.bob_bhr_r_o), 64'(12'h14A));
    check("t3_tail", 64'(bus.alloc_tag_o), 64'(2));
    check("t3_count", 64'(bus.count_o), 64'(2));
    drain();

    // Flush takes priority over a ready retire.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      alloc(64'h4000 + 64'(4 * i), BHR_W'(i), LH_W'(i), 1'b1);
      tick();
    end
    resolve(0, 1'b1);
    tick();
    resolve(3, 1'b0);
    tick();
    check("t4_flush_first", 64'(bus.flush_o), 64'(1));
    check("t4_no_ud", 64'(bus.bpd_rt_ud_o), 64'(0));
    tick();
    check("t4_retire_next", 64'(bus.bpd_rt_ud_o), 64'(1));
    check("t4_retire_pc", bus.bob_pc_r_o, 64'h4000);
    drain();

    // Out-of-order resolution retires in order.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      alloc(64'h5000 + 64'(4 * i), BHR_W'(i), LH_W'(i), 1'b0);
      tick();
    end
    resolve(2, 1'b0);
    tick();
    resolve(0, 1'b0);
    tick();
    check("t5_no_early", 64'(bus.bpd_rt_ud_o), 64'(0));
    resolve(1, 1'b0);
    tick();
    check("t5_pc0", bus.bob_pc_r_o, 64'h5000);
    tick();
    check("t5_pc1", bus.bob_pc_r_o, 64'h5004);
    tick();
    check("t5_pc2", bus.bob_pc_r_o, 64'h5008);

    // Pointer wrap with 40 alloc/resolve pairs.
    reset_dut();
    start_ud  = ud_seen;
    prev_pred = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic p;
      p = 1'($urandom_range(0, 1));
      alloc(64'h8000_0000 + 64'(4 * i), BHR_W'($urandom), LH_W'($urandom), p);
      if (i > 0) resolve((i - 1) % DEPTH, prev_pred);
      prev_pred = p;
      tick();
    end
    drain();
    check("t6_retires", 64'(ud_seen - start_ud), 64'(40));
    check("t6_noflush", 64'(fl_seen), 64'(0));

    // Random traffic with mispredicts and stale tags, then reset mid-operation.
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7)
        alloc({32'h0, $urandom}, BHR_W'($urandom), LH_W'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1)
        resolve(int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    reset_dut();
    alloc(64'h9000, '0, '0, 1'b1);
    tick();
    check("rst_mid_tag", 64'(bus.alloc_tag_o), 64'(1));
    drain();
    reset_dut();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
